// File: rtl/rv32i_fetch_pkg.sv
// Shared types and helpers for the RV32I instruction fetch slice.
package rv32i_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word aligned and inside a 2^addr_w word memory; also catches pc+4 wrap.
  function automatic logic addr_legal(input logic [XLEN-1:0] addr, input int unsigned addr_w);
    logic [XLEN-1:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} pairs; flush beats push and pop.
module fetch_buffer
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage needs no reset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_controller.sv
// RV32I fetch sequencer: owns the PC, reads the combinational imem and
// buffers {pc, instr} pairs toward decode with redirect/halt/fault handling.
module fetch_controller
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned INSTR_LEN  = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [31:0]          i_boot_pc,
  output logic [ADDR_W-1:0]    o_imem_addr,
  input  logic [INSTR_LEN-1:0] i_imem_data,
  output logic [INSTR_LEN-1:0] o_instr,
  output logic [31:0]          o_instr_pc,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  input  logic                 i_redirect,
  input  logic [31:0]          i_redirect_pc,
  input  logic                 i_halt,
  output logic                 o_busy,
  output logic                 o_fault,
  output logic [31:0]          o_fault_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            fault_next;
  logic [XLEN-1:0] fault_pc_next;

  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  logic [CNT_W-1:0] count;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  logic pc_ok;
  logic boot_ok;
  logic redir_ok;
  logic fetch_go;

  assign pc_ok    = addr_legal(pc, ADDR_W);
  assign boot_ok  = addr_legal(i_boot_pc, ADDR_W);
  assign redir_ok = addr_legal(i_redirect_pc, ADDR_W);

  assign pop      = !empty && i_instr_ready;
  assign fetch_go = (state == FETCH) && !i_redirect && !i_halt && (!full || pop);

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = XLEN'(i_imem_data);

  fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buffer (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign o_imem_addr   = pc[ADDR_W+1:2];
  assign o_instr       = INSTR_LEN'(head.instr);
  assign o_instr_pc    = head.pc;
  assign o_instr_valid = !empty;
  assign o_busy        = (state == FETCH) || (count != '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; inside FETCH redirect beats halt beats fetch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (i_redirect)                state_next = redir_ok ? FETCH : FAULT;
        else if (i_halt)               state_next = HALTED;
        else if (fetch_go && !pc_ok)   state_next = FAULT;
      end
      default: begin
        if (i_start) state_next = boot_ok ? FETCH : FAULT;
      end
    endcase
  end

  // Output / datapath control
  always_comb begin
    push          = 1'b0;
    flush         = 1'b0;
    pc_next       = pc;
    fault_next    = o_fault;
    fault_pc_next = o_fault_pc;
    case (state)
      FETCH: begin
        if (i_redirect) begin
          flush = 1'b1;
          if (redir_ok) begin
            pc_next = i_redirect_pc;
          end else begin
            fault_next    = 1'b1;
            fault_pc_next = i_redirect_pc;
          end
        end else if (fetch_go) begin
          if (pc_ok) begin
            push    = 1'b1;
            pc_next = pc + XLEN'(PC_STEP);
          end else begin
            fault_next    = 1'b1;
            fault_pc_next = pc;
          end
        end
      end
      default: begin
        if (i_start) begin
          flush = 1'b1;
          if (boot_ok) begin
            pc_next    = i_boot_pc;
            fault_next = 1'b0;
          end else begin
            fault_next    = 1'b1;
            fault_pc_next = i_boot_pc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc         <= '0;
      o_fault    <= 1'b0;
      o_fault_pc <= '0;
    end else begin
      pc         <= pc_next;
      o_fault    <= fault_next;
      o_fault_pc <= fault_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against an imem holding 0x1000+word.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] boot_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        busy;
  logic        fault;
  logic [31:0] fault_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'h1000 + 32'(imem_addr);

  fetch_controller #(.ADDR_W(10), .INSTR_LEN(32), .FIFO_DEPTH(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_boot_pc     (boot_pc),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .o_busy        (busy),
    .o_fault       (fault),
    .o_fault_pc    (fault_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; boot_pc = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_vec++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin n_err++; $display("FAIL reset_fault: got %0b/%h want 0/0", fault, fault_pc); end
    n_vec++; if (imem_addr !== 10'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_vec++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_head: got %h/%h want 0/0", instr_pc, instr); end
  endtask

  task automatic test_start_stream();
    instr_ready = 1'b1; start = 1'b1; boot_pc = 32'h10;
    tick();
    start = 1'b0;
    n_vec++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL start_bubble: got valid %0b busy %0b want 0 1", instr_valid, busy); end
    n_vec++; if (imem_addr !== 10'd4) begin n_err++; $display("FAIL start_addr: got %h want 4", imem_addr); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== 32'h1004) begin n_err++; $display("FAIL stream_0: got %0b %h/%h want 1 10/1004", instr_valid, instr_pc, instr); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14 || instr !== 32'h1005) begin n_err++; $display("FAIL stream_1: got %0b %h/%h want 1 14/1005", instr_valid, instr_pc, instr); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h18 || instr !== 32'h1006) begin n_err++; $display("FAIL stream_2: got %0b %h/%h want 1 18/1006", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got valid %0b busy %0b want 0 0", instr_valid, busy); end
    n_vec++; if (imem_addr !== 10'd0 || fault !== 1'b0) begin n_err++; $display("FAIL midrst_pc: got addr %h fault %0b want 0 0", imem_addr, fault); end
    tick();
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stays: got %0b want 0", instr_valid); end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0; start = 1'b1; boot_pc = 32'h10;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    n_vec++; if (imem_addr !== 10'd6) begin n_err++; $display("FAIL bp_addr_hold: got %h want 6", imem_addr); end
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== 32'h1004) begin n_err++; $display("FAIL bp_head: got %0b %h/%h want 1 10/1004", instr_valid, instr_pc, instr); end
    instr_ready = 1'b1;
    tick();
    n_vec++; if (instr_pc !== 32'h14 || instr !== 32'h1005) begin n_err++; $display("FAIL bp_drain_1: got %h/%h want 14/1005", instr_pc, instr); end
    tick();
    n_vec++; if (instr_pc !== 32'h18 || instr !== 32'h1006) begin n_err++; $display("FAIL bp_drain_2: got %h/%h want 18/1006", instr_pc, instr); end
    tick();
    n_vec++; if (instr_pc !== 32'h1c || instr !== 32'h1007) begin n_err++; $display("FAIL bp_drain_3: got %h/%h want 1c/1007", instr_pc, instr); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %0b want 0", instr_valid); end
    n_vec++; if (imem_addr !== 10'h40) begin n_err++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h1040) begin n_err++; $display("FAIL redir_first: got %0b %h/%h want 1 100/1040", instr_valid, instr_pc, instr); end
    tick();
    n_vec++; if (instr_pc !== 32'h104 || instr !== 32'h1041) begin n_err++; $display("FAIL redir_second: got %h/%h want 104/1041", instr_pc, instr); end
  endtask

  task automatic test_fault_redirect();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    n_vec++; if (fault !== 1'b1 || fault_pc !== 32'h102) begin n_err++; $display("FAIL fredir_fault: got %0b/%h want 1/102", fault, fault_pc); end
    n_vec++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL fredir_empty: got valid %0b busy %0b want 0 0", instr_valid, busy); end
  endtask

  task automatic test_fault_overrun();
    instr_ready = 1'b1; start = 1'b1; boot_pc = 32'hff8;
    tick();
    start = 1'b0;
    n_vec++; if (fault !== 1'b0 || imem_addr !== 10'h3fe) begin n_err++; $display("FAIL ovr_start: got fault %0b addr %h want 0 3fe", fault, imem_addr); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'hff8 || instr !== 32'h13fe) begin n_err++; $display("FAIL ovr_ff8: got %0b %h/%h want 1 ff8/13fe", instr_valid, instr_pc, instr); end
    tick();
    n_vec++; if (instr_pc !== 32'hffc || instr !== 32'h13ff || fault !== 1'b0) begin n_err++; $display("FAIL ovr_ffc: got %h/%h fault %0b want ffc/13ff 0", instr_pc, instr, fault); end
    tick();
    n_vec++; if (fault !== 1'b1 || fault_pc !== 32'h1000) begin n_err++; $display("FAIL ovr_fault: got %0b/%h want 1/1000", fault, fault_pc); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ovr_no_push: got %0b want 0", instr_valid); end
  endtask

  task automatic test_halt_resume();
    instr_ready = 1'b0; start = 1'b1; boot_pc = 32'h0;
    tick();
    start = 1'b0;
    n_vec++; if (fault !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL restart_clear: got fault %0b busy %0b want 0 1", fault, busy); end
    tick(); tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_vec++; if (busy !== 1'b1 || imem_addr !== 10'd2) begin n_err++; $display("FAIL halt_hold: got busy %0b addr %h want 1 2", busy, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    n_vec++; if (imem_addr !== 10'd2 || instr_pc !== 32'h0 || instr !== 32'h1000) begin n_err++; $display("FAIL halt_redir_ignored: got addr %h head %h/%h want 2 0/1000", imem_addr, instr_pc, instr); end
    instr_ready = 1'b1;
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== 32'h1001) begin n_err++; $display("FAIL halt_drain: got %0b %h/%h want 1 4/1001", instr_valid, instr_pc, instr); end
    tick();
    n_vec++; if (instr_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 10'd2) begin n_err++; $display("FAIL halt_idle: got valid %0b busy %0b addr %h want 0 0 2", instr_valid, busy, imem_addr); end
    start = 1'b1; boot_pc = 32'h20;
    tick();
    start = 1'b0;
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'h1008) begin n_err++; $display("FAIL resume_first: got %0b %h/%h want 1 20/1008", instr_valid, instr_pc, instr); end
    start = 1'b1; boot_pc = 32'h300;
    tick();
    start = 1'b0;
    n_vec++; if (instr_pc !== 32'h24 || instr !== 32'h1009) begin n_err++; $display("FAIL start_in_fetch_ignored: got %h/%h want 24/1009", instr_pc, instr); end
  endtask

  initial begin
    test_reset();
    test_start_stream();
    test_reset_midstream();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_fault_overrun();
    test_halt_resume();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
